// File: rtl/dac_stream_pkg.sv
// Shared constants and types for the delta-sigma DAC transmit path.
// Dither LFSR constants are used only when DAC_STREAM_TX_DITHER_EN is defined.
package dac_stream_pkg;

    localparam int DW_DEF         = 4;
    localparam int OSR_DEF        = 16;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef logic [DW_DEF-1:0] sample_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 counted from 1 at the LSB
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/dac_stream_fifo.sv
// Small synchronous sample FIFO with registered level and flags.
// rdata shows the head entry combinationally from registered state.
module dac_stream_fifo #(
    parameter int DW    = 4,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic          w_push;
    logic          w_pop;

    assign full   = (r_level == (AW+1)'(DEPTH));
    assign empty  = (r_level == '0);
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign rdata  = r_mem[r_rd_ptr];
    assign level  = r_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/dac_stream_tx.sv
// FIFO-fed first-order delta-sigma 1-bit DAC stream; underrun is registered.
// Define DAC_STREAM_TX_DITHER_EN to add LFSR carry-in dither.
module dac_stream_tx
    import dac_stream_pkg::*;
#(
    parameter int DW         = DW_DEF,
    parameter int OSR        = OSR_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    localparam int PW        = $clog2(OSR),
    localparam int LW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          dac_out,
    output logic          underrun,
    output logic [LW-1:0] fifo_level
);

    logic [PW-1:0] r_phase;
    logic [DW-1:0] r_acc;
    logic [DW-1:0] r_cur;
    logic          r_dac;
    logic          r_underrun;

    logic [DW-1:0] w_rdata;
    logic [LW-1:0] w_level;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_boundary;
    logic          w_pop;
    logic [DW-1:0] w_mod_in;
    logic          w_cin;
    logic [DW:0]   w_sum;

    assign w_push     = in_valid && !w_full;
    assign w_boundary = en && (r_phase == '0);
    assign w_pop      = w_boundary && !w_empty;
    assign w_mod_in   = w_pop ? w_rdata : r_cur;
    assign w_sum      = {1'b0, r_acc} + {1'b0, w_mod_in} + (DW+1)'(w_cin);

    assign in_ready   = !w_full;
    assign dac_out    = r_dac;
    assign underrun   = r_underrun;
    assign fifo_level = w_level;

    dac_stream_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (in_data),
        .rdata (w_rdata),
        .level (w_level),
        .full  (w_full),
        .empty (w_empty)
    );

`ifdef DAC_STREAM_TX_DITHER_EN
    logic [15:0] r_lfsr;

    assign w_cin = r_lfsr[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= LFSR_SEED;
        end else if (en) begin
            r_lfsr <= lfsr_next(r_lfsr);
        end else begin
            r_lfsr <= LFSR_SEED;
        end
    end
`else
    assign w_cin = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase    <= '0;
            r_acc      <= '0;
            r_cur      <= '0;
            r_dac      <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= w_boundary && w_empty;
            if (w_pop) begin
                r_cur <= w_rdata;
            end
            // Phase wraps naturally since OSR is a power of two
            if (en) begin
                r_phase <= r_phase + 1'b1;
                r_acc   <= w_sum[DW-1:0];
                r_dac   <= w_sum[DW];
            end else begin
                r_phase <= '0;
                r_acc   <= '0;
                r_dac   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dac_stream_tx.sv
// Directed self-checking bench for dac_stream_tx (default build, no dither).
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_dac_stream_tx;
    import dac_stream_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    sample_t    in_data;
    logic       in_valid;
    logic       in_ready;
    logic       dac_out;
    logic       underrun;
    logic [2:0] fifo_level;

    int n_checks = 0;
    int n_err    = 0;
    int ones;
    int urn;
    int flag;
    logic [15:0] pat;

    dac_stream_tx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dac_out    (dac_out),
        .underrun   (underrun),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_one(input int code);
        in_data  = sample_t'(code);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        in_data  = '0;
        in_valid = 1'b0;
        #2;
        chk("rst_dac", int'(dac_out), 0);
        chk("rst_underrun", int'(underrun), 0);
        chk("rst_level", int'(fifo_level), 0);
        chk("rst_ready", int'(in_ready), 1);
        tick();
        rst_n = 1'b1;
        tick();

        // Code 0: silent output, underrun at each later boundary
        push_one(0);
        chk("t1_level", int'(fifo_level), 1);
        en = 1'b1;
        ones = 0;
        urn  = 0;
        for (int n = 1; n <= 64; n++) begin
            tick();
            ones += int'(dac_out);
            if (n == 1) chk("t1_no_urn_first", int'(underrun), 0);
            if (n == 17 || n == 33 || n == 49) urn += int'(underrun);
            else if (underrun) urn += 100;
        end
        chk("t1_ones", ones, 0);
        chk("t1_underruns", urn, 3);
        en = 1'b0;
        tick();

        // Code 15: 15 ones in the first period
        push_one(15);
        en   = 1'b1;
        ones = 0;
        flag = 1;
        for (int n = 1; n <= 16; n++) begin
            tick();
            ones += int'(dac_out);
            if (!in_ready) flag = 0;
        end
        chk("t2_ones", ones, 15);
        chk("t2_ready", flag, 1);
        en = 1'b0;
        tick();

        // Code 8: alternating pattern starting with 0
        push_one(8);
        en  = 1'b1;
        pat = '0;
        for (int k = 0; k < 16; k++) begin
            tick();
            pat[k] = dac_out;
        end
        chk("t3_pattern", int'(pat), 'hAAAA);
        en = 1'b0;
        tick();

        // Fill past full with en=0, then drain in order
        chk("t4_ready0", int'(in_ready), 1);
        in_valid = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            in_data = sample_t'(c);
            tick();
        end
        in_valid = 1'b0;
        chk("t4_level_full", int'(fifo_level), 4);
        chk("t4_ready_full", int'(in_ready), 0);
        en = 1'b1;
        for (int p = 0; p < 4; p++) begin
            ones = 0;
            for (int j = 0; j < 16; j++) begin
                tick();
                ones += int'(dac_out);
                if (j == 0) chk("t4_level_dec", int'(fifo_level), 3 - p);
            end
            chk("t4_period_ones", ones, p + 1);
        end
        tick();
        chk("t4_underrun_empty", int'(underrun), 1);
        en = 1'b0;
        tick();

        // Code 4 interrupted at phase 7, then resumed on held sample
        push_one(4);
        en   = 1'b1;
        ones = 0;
        for (int n = 0; n < 7; n++) begin
            tick();
            ones += int'(dac_out);
        end
        chk("t5_ones_partial", ones, 1);
        en   = 1'b0;
        flag = 1;
        for (int n = 0; n < 3; n++) begin
            tick();
            if (dac_out || underrun) flag = 0;
        end
        chk("t5_idle_quiet", flag, 1);
        en   = 1'b1;
        ones = 0;
        for (int n = 1; n <= 16; n++) begin
            tick();
            ones += int'(dac_out);
            if (n == 1) chk("t5_restart_urn", int'(underrun), 1);
        end
        chk("t5_ones_resume", ones, 4);
        en = 1'b0;
        tick();

        // Asynchronous reset mid-period with 3 entries queued
        in_valid = 1'b1;
        in_data  = sample_t'(15);
        for (int n = 0; n < 4; n++) tick();
        in_valid = 1'b0;
        en = 1'b1;
        for (int n = 0; n < 5; n++) tick();
        chk("t6_level_pre", int'(fifo_level), 3);
        chk("t6_dac_pre", int'(dac_out), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_dac", int'(dac_out), 0);
        chk("t6_async_level", int'(fifo_level), 0);
        chk("t6_async_ready", int'(in_ready), 1);
        en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_level_post", int'(fifo_level), 0);
        chk("t6_ready_post", int'(in_ready), 1);
        chk("t6_underrun_post", int'(underrun), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/dac_stream_tx.md
Name: dac_stream_tx

Overview:
- Digital-to-analog transmit path of the chip. It is the reverse of the comparator-based front end that turns the analog `in` into the 4-bit `out`.
- Accepts 4-bit sample codes over a valid/ready handshake and buffers them in a small FIFO.
- Replays each code for OSR clock cycles as a first-order delta-sigma 1-bit stream. The stream drives an external RC/analog reconstruction stage through anatop.

Parameters:
- DW, 4: sample code width in bits; matches chiptop `out`.
- OSR, 16: clock cycles per sample period. Power of two, at least 2.
- FIFO_DEPTH, 4: sample buffer entries. Power of two, at least 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  modulator enable; FIFO writes are accepted regardless of en
- in_data  in  DW  sample code, unsigned
- in_valid  in  1  in_data is valid
- in_ready  out  1  FIFO can accept a sample
- dac_out  out  1  registered delta-sigma bitstream
- underrun  out  1  one-cycle pulse: sample boundary reached with FIFO empty
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of stored entries

Behaviour:
- Reset (async assert, sync release) gives:
  - dac_out=0, underrun=0, fifo_level=0, in_ready=1
  - cur_sample=0, acc=0, phase counter=0
  - FIFO pointers=0
- Push rule:
  - A push occurs when in_valid && in_ready on a rising clk edge.
  - in_ready = (fifo_level != FIFO_DEPTH), decoded from registered state only. There is no combinational path from in_valid.
- Full: in_ready=0, in_valid is ignored, and no data is lost or overwritten.
- No bypass: a sample pushed in cycle t is never popped in cycle t.
- Phase counter:
  - Counts 0..OSR-1 while en=1 and wraps to 0.
  - While en=0 it is held at 0.
- Sample boundary = en && phase==0. At a boundary:
  - If FIFO not empty: pop the head into cur_sample; underrun stays 0.
  - If FIFO empty: cur_sample is held; underrun=1 for exactly that cycle.
- Simultaneous push and pop in one cycle: both take effect; fifo_level is unchanged.
- Modulator, each cycle with en=1:
  - sum[DW:0] = acc + mod_in, where mod_in = the sample just popped in a pop cycle, else cur_sample.
  - dac_out <= sum[DW]; acc <= sum[DW-1:0].
  - Result: over one sample period exactly code ±1 ones per OSR=2^DW cycles. With continuous identical codes the long-run ones density is code/2^DW exactly.
- Latency:
  - The first popped sample affects dac_out one cycle after the boundary edge.
  - Empty FIFO with en=1 at phase 0: a push in cycle t is popped at the next boundary.
- en falling, including mid-period:
  - Next edge: dac_out=0, acc=0, phase=0.
  - cur_sample and FIFO contents are retained.
- en rising: that first cycle is a boundary.
- Arithmetic: all values unsigned. acc is DW bits and wraps naturally; the carry is the output bit.
- Reset asserted mid-operation: all state clears immediately (async) and FIFO contents are discarded.

Optional Feature:
- Macro: DAC_STREAM_TX_DITHER_EN.
- Defined:
  - 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1) advances every en cycle.
  - Its bit 0 is added as carry-in to sum.
  - The LFSR resets to the seed on rst_n and when en=0.
  - Breaks idle tones; ones density rises by up to +1/2 LSB.
- Undefined: carry-in is constant 0, no LFSR logic, and the exact-count behaviour above holds.

Decomposition:
- Package dac_stream_pkg:
  - DW_DEF, OSR_DEF, FIFO_DEPTH_DEF
  - typedef logic [DW_DEF-1:0] sample_t
  - LFSR_SEED, LFSR_TAPS
- Sub-module dac_stream_fifo:
  - Synchronous FIFO, one clock, async active-low reset.
  - Ports: push/pop/wdata/rdata/level/full/empty.
- The top level holds the phase counter, boundary logic, accumulator and optional LFSR.

Test Plan (dither macro undefined unless stated):
- Reset, then push code 0, en=1 → dac_out stays 0 for 64 cycles; underrun pulses at each later boundary (cycles 16, 32, 48).
- Push code 15 once, en=1 → exactly 15 ones in the first 16 dac_out cycles; in_ready stays 1.
- Push code 8 → dac_out alternates 0,1,0,1… within the period (8 ones in 16 cycles).
- en=0, push 5 codes → in_ready=0 after the 4th push; fifo_level=4; the 5th is dropped. en=1 → codes emerge in order, one per 16 cycles, and fifo_level decrements at each boundary.
- Push code 4, deassert en at phase 7, reassert → dac_out=0 while en=0; the new period restarts at phase 0 with acc=0 and reuses cur_sample=4 if the FIFO is empty (underrun=1 at restart).
- Assert rst_n=0 mid-period with 3 entries queued → outputs clear asynchronously without waiting for clk; fifo_level=0 and in_ready=1 after release. With DAC_STREAM_TX_DITHER_EN, code 0 yields a nonzero but ≤1-per-16-cycle ones count.
